// File: rtl/train_sequencer_pkg.sv
// Shared types and default widths for the linear-regression engine.
// The serial loader, the RAM and the SGD core use the same defaults.
package train_sequencer_pkg;

    localparam int unsigned DEF_ADDR_WIDTH    = 12;
    localparam int unsigned DEF_FEAT_WIDTH    = 4;
    localparam int unsigned DEF_EPOCH_WIDTH   = 8;
    localparam int unsigned DEF_MAX_FEATURES  = 15;
    localparam int unsigned DEF_HOLD_CYCLES   = 500;
    localparam int unsigned DEF_TIMEOUT_WIDTH = 20;
    localparam int unsigned LR_WIDTH          = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SER_IN = 3'd2,
        ST_SGD    = 3'd3,
        ST_HOLD   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_CONFIG      = 2'd1,
        ERR_SER_TIMEOUT = 2'd2,
        ERR_SGD_TIMEOUT = 2'd3
    } err_code_t;

endpackage

// File: rtl/train_sequencer_if.sv
// Control/status bundle between the sequencer and the loader, RAM and SGD core.
interface train_sequencer_if
    import train_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned FEAT_WIDTH  = DEF_FEAT_WIDTH,
    parameter int unsigned EPOCH_WIDTH = DEF_EPOCH_WIDTH
) ();

    logic                   ser_flag;
    logic                   ser_done;
    logic [ADDR_WIDTH-1:0]  ser_addr;
    logic                   sgd_done;
    logic [ADDR_WIDTH-1:0]  sgd_addr;

    logic                   ser_rst;
    logic                   ram_rst;
    logic                   sgd_rst;
    logic                   sgd_hold;
    logic                   ram_we;
    logic                   ram_oe;
    logic [ADDR_WIDTH-1:0]  ram_addr;

    logic [FEAT_WIDTH-1:0]  cfg_feat;
    logic [ADDR_WIDTH-1:0]  cfg_dp;
    logic [EPOCH_WIDTH-1:0] cfg_epoch;
    logic [LR_WIDTH-1:0]    cfg_lr;

    modport master (
        input  ser_flag, ser_done, ser_addr, sgd_done, sgd_addr,
        output ser_rst, ram_rst, sgd_rst, sgd_hold, ram_we, ram_oe, ram_addr,
        output cfg_feat, cfg_dp, cfg_epoch, cfg_lr
    );

    modport slave (
        output ser_flag, ser_done, ser_addr, sgd_done, sgd_addr,
        input  ser_rst, ram_rst, sgd_rst, sgd_hold, ram_we, ram_oe, ram_addr,
        input  cfg_feat, cfg_dp, cfg_epoch, cfg_lr
    );

endinterface

// File: rtl/train_sequencer_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/train_sequencer.sv
// Run sequencer: latches a configuration on start, then steps load -> train ->
// write-back hold and returns to idle; config errors and stalls park in ERROR.
module train_sequencer
    import train_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int unsigned MAX_FEATURES  = DEF_MAX_FEATURES,
    parameter int unsigned FEAT_WIDTH    = DEF_FEAT_WIDTH,
    parameter int unsigned EPOCH_WIDTH   = DEF_EPOCH_WIDTH,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic                   skip_load,
    input  logic [FEAT_WIDTH-1:0]  feat,
    input  logic [ADDR_WIDTH-1:0]  data_points,
    input  logic [EPOCH_WIDTH-1:0] epoch,
    input  logic [LR_WIDTH-1:0]    learn_rate,
    train_sequencer_if.master      ctl,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [2:0]             state
);

    localparam int unsigned HOLD_WIDTH = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_CYCLES - 1);

    state_t                 state_q, state_d;
    err_code_t              err_code_q, err_code_d;
    logic                   err_q, done_q, skip_q;
    logic [FEAT_WIDTH-1:0]  feat_q;
    logic [ADDR_WIDTH-1:0]  dp_q;
    logic [EPOCH_WIDTH-1:0] epoch_q;
    logic [LR_WIDTH-1:0]    lr_q;
    logic [TIMEOUT_WIDTH-1:0] wd_count;
    logic [HOLD_WIDTH-1:0]  hold_count;
    logic start_ok, cfg_bad, wd_active, wd_expired;

    assign start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_ERROR));
    assign cfg_bad    = (feat_q == '0) || (32'(feat_q) > MAX_FEATURES) ||
                        (dp_q == '0) || (epoch_q == '0);
    assign wd_active  = (state_q == ST_SER_IN) || (state_q == ST_SGD);
    assign wd_expired = (wd_count == '1);

    // Watchdog restarts on any state change, so it measures time spent in one phase.
    sat_counter #(.WIDTH(TIMEOUT_WIDTH)) u_watchdog (
        .clk   (CLK),
        .rst   (RST),
        .clear ((state_d != state_q) || !wd_active),
        .en    (wd_active),
        .count (wd_count)
    );

    sat_counter #(.WIDTH(HOLD_WIDTH)) u_hold (
        .clk   (CLK),
        .rst   (RST),
        .clear (state_q != ST_HOLD),
        .en    (state_q == ST_HOLD),
        .count (hold_count)
    );

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_CHECK;
            ST_CHECK: begin
                if (cfg_bad) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_CONFIG;
                end else begin
                    state_d = skip_q ? ST_SGD : ST_SER_IN;
                end
            end
            ST_SER_IN: begin
                if (ctl.ser_done) begin
                    state_d = ST_SGD;
                end else if (wd_expired) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_SER_TIMEOUT;
                end
            end
            ST_SGD: begin
                if (ctl.sgd_done) begin
                    state_d = ST_HOLD;
                end else if (wd_expired) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_SGD_TIMEOUT;
                end
            end
            ST_HOLD:  if (hold_count == HOLD_LAST) state_d = ST_IDLE;
            ST_ERROR: if (start_ok) state_d = ST_CHECK;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            err_code_q <= ERR_NONE;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            skip_q     <= 1'b0;
            feat_q     <= '0;
            dp_q       <= '0;
            epoch_q    <= '0;
            lr_q       <= '0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            err_q      <= (state_d == ST_ERROR);
            done_q     <= (state_q == ST_HOLD) && (state_d == ST_IDLE);
            if (start_ok) begin
                skip_q  <= skip_load;
                feat_q  <= feat;
                dp_q    <= data_points;
                epoch_q <= epoch;
                lr_q    <= learn_rate;
            end
        end
    end

    always_comb begin
        ctl.ser_rst  = 1'b1;
        ctl.ram_rst  = 1'b1;
        ctl.sgd_rst  = 1'b1;
        ctl.sgd_hold = 1'b0;
        ctl.ram_we   = 1'b0;
        ctl.ram_oe   = 1'b0;
        ctl.ram_addr = '0;
        case (state_q)
            ST_CHECK: ctl.ram_rst = 1'b0;
            ST_SER_IN: begin
                ctl.ser_rst  = 1'b0;
                ctl.ram_rst  = 1'b0;
                ctl.ram_we   = !ctl.ser_flag && !ctl.ser_done;
                ctl.ram_addr = ctl.ser_addr;
            end
            ST_SGD: begin
                ctl.ram_rst  = 1'b0;
                ctl.sgd_rst  = 1'b0;
                ctl.ram_oe   = 1'b1;
                ctl.ram_addr = ctl.sgd_addr;
            end
            ST_HOLD: begin
                ctl.ram_rst  = 1'b0;
                ctl.sgd_rst  = 1'b0;
                ctl.sgd_hold = 1'b1;
                ctl.ram_we   = 1'b1;
                ctl.ram_addr = ctl.sgd_addr;
            end
            default: ;
        endcase
    end

    assign busy          = (state_q == ST_CHECK) || (state_q == ST_SER_IN) ||
                           (state_q == ST_SGD) || (state_q == ST_HOLD);
    assign done          = done_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign state         = state_q;
    assign ctl.cfg_feat  = feat_q;
    assign ctl.cfg_dp    = dp_q;
    assign ctl.cfg_epoch = epoch_q;
    assign ctl.cfg_lr    = lr_q;

endmodule

// File: tb/tb_train_sequencer.sv
// Bench for train_sequencer: each run is modelled as a list of phase lengths
// (load, train, hold) and every cycle's outputs are compared against that timeline.
module tb_train_sequencer;

    localparam int unsigned AW   = 12;
    localparam int unsigned FW   = 4;
    localparam int unsigned EW   = 8;
    localparam int unsigned HOLD = 500;
    localparam int unsigned TW   = 6;
    localparam int WD_CYC = 1 << TW;

    localparam int P_IDLE = 0, P_CHECK = 1, P_SER = 2, P_SGD = 3, P_HOLD = 4, P_ERR = 5;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          RST, start, skip_load;
    logic [FW-1:0] feat;
    logic [AW-1:0] data_points;
    logic [EW-1:0] epoch;
    logic [3:0]    learn_rate;
    logic          busy, done, err;
    logic [1:0]    err_code;
    logic [2:0]    state;

    train_sequencer_if #(.ADDR_WIDTH(AW), .FEAT_WIDTH(FW), .EPOCH_WIDTH(EW)) ctl ();

    train_sequencer #(
        .ADDR_WIDTH(AW), .MAX_FEATURES(15), .FEAT_WIDTH(FW), .EPOCH_WIDTH(EW),
        .HOLD_CYCLES(HOLD), .TIMEOUT_WIDTH(TW)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .skip_load(skip_load),
        .feat(feat), .data_points(data_points), .epoch(epoch), .learn_rate(learn_rate),
        .ctl(ctl.master),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .state(state)
    );

    int nvec = 0;
    int nfail = 0;

    // Expectation for the cycle the next run/idle call begins on.
    int          entry_ph;
    logic        entry_done;
    logic [1:0]  last_code;
    logic [27:0] cfg_exp;

    function automatic logic [13:0] exp_ctl(input int ph, input logic flag, input logic sdone,
                                            input logic dn, input logic [1:0] code);
        logic b, e, sr, rr, gr, h, we, oe;
        b  = (ph == P_CHECK) || (ph == P_SER) || (ph == P_SGD) || (ph == P_HOLD);
        e  = (ph == P_ERR);
        sr = (ph != P_SER);
        rr = (ph == P_IDLE) || (ph == P_ERR);
        gr = !((ph == P_SGD) || (ph == P_HOLD));
        h  = (ph == P_HOLD);
        we = ((ph == P_SER) && !flag && !sdone) || (ph == P_HOLD);
        oe = (ph == P_SGD);
        return {3'(ph), b, dn, e, code, sr, rr, gr, h, we, oe};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        assert (act === expv) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, act, expv, $time);
        end
    endtask

    task automatic cycle(input int ph, input logic dn, input logic [27:0] cfgx, input logic st,
                         input logic [3:0] f, input logic [11:0] d, input logic [7:0] e,
                         input logic [3:0] lr, input logic sk, input logic sdone,
                         input logic gdone, input logic rst);
        logic        flag;
        logic [11:0] saddr, gaddr, addr_exp;
        flag  = 1'($urandom);
        saddr = 12'($urandom);
        gaddr = 12'($urandom);
        RST = rst; start = st; skip_load = sk;
        feat = f; data_points = d; epoch = e; learn_rate = lr;
        ctl.ser_flag = flag; ctl.ser_done = sdone; ctl.ser_addr = saddr;
        ctl.sgd_done = gdone; ctl.sgd_addr = gaddr;
        #1;
        case (ph)
            P_SER:         addr_exp = saddr;
            P_SGD, P_HOLD: addr_exp = gaddr;
            default:       addr_exp = '0;
        endcase
        check("ctl", 32'({state, busy, done, err, err_code, ctl.ser_rst, ctl.ram_rst,
                          ctl.sgd_rst, ctl.sgd_hold, ctl.ram_we, ctl.ram_oe}),
              32'(exp_ctl(ph, flag, sdone, dn, last_code)));
        check("ram_addr", 32'(ctl.ram_addr), 32'(addr_exp));
        check("cfg", 32'({ctl.cfg_feat, ctl.cfg_dp, ctl.cfg_epoch, ctl.cfg_lr}), 32'(cfgx));
        @(posedge CLK);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(entry_ph, entry_done, cfg_exp, 1'b0, 4'($urandom), 12'($urandom),
                  8'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
            entry_done = 1'b0;
        end
    endtask

    // ser_d/sgd_d: in-phase cycle index of the done pulse (-1 = never);
    // rst_k: train-phase cycle index at which RST is raised (-1 = never).
    task automatic run(input logic [3:0] f, input logic [11:0] d, input logic [7:0] e,
                       input logic [3:0] lr, input logic sk, input int ser_d,
                       input int sgd_d, input int rst_k);
        logic        bad, ser_to, sgd_to, use_rst;
        int          ser_len, sgd_len, last, ph, idx, p;
        logic [27:0] cfg_run;
        cfg_run = {f, d, e, lr};
        bad     = (f == 0) || (f > 15) || (d == 0) || (e == 0);
        if (sk) begin
            ser_len = 0; ser_to = 1'b0;
        end else if (ser_d >= 0 && ser_d < WD_CYC) begin
            ser_len = ser_d + 1; ser_to = 1'b0;
        end else begin
            ser_len = WD_CYC; ser_to = 1'b1;
        end
        if (sgd_d >= 0 && sgd_d < WD_CYC) begin
            sgd_len = sgd_d + 1; sgd_to = 1'b0;
        end else begin
            sgd_len = WD_CYC; sgd_to = 1'b1;
        end
        use_rst = !bad && !ser_to && rst_k >= 0 && rst_k < sgd_len;
        if (bad)          last = 2;
        else if (ser_to)  last = 2 + ser_len;
        else if (use_rst) last = 2 + ser_len + rst_k + 1;
        else if (sgd_to)  last = 2 + ser_len + sgd_len;
        else              last = 2 + ser_len + sgd_len + int'(HOLD);

        for (int t = 0; t < last; t++) begin
            if (t == 0) begin
                cycle(entry_ph, entry_done, cfg_exp, 1'b1, f, d, e, lr, sk, 1'b0, 1'b0, 1'b0);
            end else begin
                idx = 0;
                if (t == 1) begin
                    ph = P_CHECK;
                end else begin
                    p = t - 2;
                    if (p < ser_len) begin
                        ph = P_SER; idx = p;
                    end else begin
                        p -= ser_len;
                        if (p < sgd_len) begin
                            ph = P_SGD; idx = p;
                        end else begin
                            ph = P_HOLD; idx = p - sgd_len;
                        end
                    end
                end
                cycle(ph, 1'b0, cfg_run, $urandom_range(0, 7) == 0, 4'($urandom),
                      12'($urandom), 8'($urandom), 4'($urandom), 1'($urandom),
                      (ph == P_SER) && (idx == ser_d), (ph == P_SGD) && (idx == sgd_d),
                      use_rst && (ph == P_SGD) && (idx == rst_k));
            end
        end

        cfg_exp    = cfg_run;
        entry_done = 1'b0;
        if (bad) begin
            entry_ph = P_ERR; last_code = 2'd1;
        end else if (ser_to) begin
            entry_ph = P_ERR; last_code = 2'd2;
        end else if (use_rst) begin
            entry_ph = P_IDLE; last_code = 2'd0; cfg_exp = '0;
        end else if (sgd_to) begin
            entry_ph = P_ERR; last_code = 2'd3;
        end else begin
            entry_ph = P_IDLE; entry_done = 1'b1;
        end
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; skip_load = 1'b0;
        feat = '0; data_points = '0; epoch = '0; learn_rate = '0;
        ctl.ser_flag = 1'b0; ctl.ser_done = 1'b0; ctl.ser_addr = '0;
        ctl.sgd_done = 1'b0; ctl.sgd_addr = '0;
        repeat (2) @(posedge CLK);
        #2;
        entry_ph = P_IDLE; entry_done = 1'b0; last_code = 2'd0; cfg_exp = '0;
        idle(3);

        // Nominal load/train/hold run, then done pulse and idle.
        run(4'd3, 12'd4, 8'd2, 4'd5, 1'b0, 20, 50, -1);
        idle(2);

        // Config error, recovery from ERROR, then a skip-load start in the done cycle.
        run(4'd0, 12'd4, 8'd2, 4'd1, 1'b0, 20, 50, -1);
        idle(2);
        run(4'd2, 12'd5, 8'd3, 4'd2, 1'b0, 10, 30, -1);
        run(4'd3, 12'd3, 8'd1, 4'd9, 1'b1, 0, 40, -1);

        // Training never finishes: watchdog error.
        run(4'd4, 12'd8, 8'd1, 4'd7, 1'b0, 5, -1, -1);
        idle(1);

        // Reset in cycle 10 of training, then a normal run.
        run(4'd5, 12'd6, 8'd2, 4'd3, 1'b0, 8, 60, 10);
        idle(1);
        run(4'd1, 12'd1, 8'd1, 4'd0, 1'b0, 0, 0, -1);

        // ser_done coincident with watchdog expiry, then a load timeout.
        run(4'd15, 12'd100, 8'd255, 4'd15, 1'b0, WD_CYC - 1, WD_CYC - 1, -1);
        run(4'd6, 12'd2, 8'd4, 4'd4, 1'b0, -1, 10, -1);
        run(4'd6, 12'd0, 8'd4, 4'd4, 1'b0, 3, 3, -1);
        run(4'd6, 12'd7, 8'd0, 4'd4, 1'b1, 3, 3, -1);
        idle(1);

        for (int r = 0; r < 8; r++) begin
            run(($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 4095)),
                ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
                4'($urandom), 1'($urandom),
                $urandom_range(0, 70), $urandom_range(0, 70), -1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
